dmem_arbiter: RTL and testbench

//  Owns the single-port synchronous data RAM; shares it between the pipeline data-read stage,
//  the write-back stage and the host/debug port. One access per cycle. Write-back is posted

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/dmem_arbiter_if.sv | 19 +
 rtl/dmem_write_buffer.sv | 42 ++++
 rtl/dmem_arbiter.sv | 57 +++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared defaults, read-source tags and round-robin pointer type
package dmem_arbiter_pkg;
  localparam int A_WIDTH_DEF = 12;
  localparam int D_WIDTH_DEF = 8;
  localparam int DEFER_MAX_DEF = 4;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_RD = 2'd1, SRC_HOST = 2'd2, SRC_FWD = 2'd3} src_e;
  typedef enum logic {RR_RD = 1'b0, RR_HOST = 1'b1} rr_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: write-back, pipeline read, host and RAM signals of the data memory arbiter
interface dmem_arbiter_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic wb_req, wb_ack, rd_req, rd_gnt, rd_valid;
  logic host_req, host_we, host_gnt, host_valid;
  logic mem_ce, mem_we, busy;
  logic [A_WIDTH-1:0] wb_addr, rd_addr, host_addr, mem_a;
  logic [D_WIDTH-1:0] wb_data, rd_data, host_wdata, host_rdata, mem_d, mem_q;
  modport slave (
    input wb_req, wb_addr, wb_data, rd_req, rd_addr, host_req, host_we, host_addr, host_wdata, mem_q,
    output wb_ack, rd_gnt, rd_valid, rd_data, host_gnt, host_valid, host_rdata, mem_ce, mem_we, mem_a, mem_d, busy
  );
  modport master (
    output wb_req, wb_addr, wb_data, rd_req, rd_addr, host_req, host_we, host_addr, host_wdata, mem_q,
    input wb_ack, rd_gnt, rd_valid, rd_data, host_gnt, host_valid, host_rdata, mem_ce, mem_we, mem_a, mem_d, busy
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: one-entry posted write buffer with read-address compare and defer counter
module dmem_write_buffer import dmem_arbiter_pkg::*; #(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int DEFER_MAX = DEFER_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               drain,
  input  logic               pend,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic               hit,
  output logic               full,
  output logic               force_drain,
  output logic [A_WIDTH-1:0] buf_addr,
  output logic [D_WIDTH-1:0] buf_data
);
  localparam int DW = $clog2(DEFER_MAX + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEFER_MAX);
  logic [DW-1:0] defer;
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= 1'b0;
      defer <= '0;
    end else begin
      full <= load | (full & !drain);
      defer <= (drain | !full) ? '0 : (defer == DMAX) ? defer : defer + DW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (load) begin
      buf_addr <= addr;
      buf_data <= data;
    end
  end
  assign hit = full & (rd_addr == buf_addr);
  // a waiting write-back or an exhausted defer budget both force the buffer out
  assign force_drain = full & (pend | defer == DMAX);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between pipeline reads, posted write-back and host
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int DEFER_MAX = DEFER_MAX_DEF
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  logic full, hit, force_drain, drain, load, rd_pick, rd_ram;
  logic [A_WIDTH-1:0] buf_addr;
  logic [D_WIDTH-1:0] buf_data, fwd_q, rd_hold, host_hold;
  rr_e rr_q, rr_d;
  src_e src_q, src_d;
  dmem_write_buffer #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .DEFER_MAX(DEFER_MAX)) u_wbuf (
    .clk(clk), .reset(reset), .load(load), .drain(drain), .pend(bus.wb_req),
    .addr(bus.wb_addr), .data(bus.wb_data), .rd_addr(bus.rd_addr),
    .hit(hit), .full(full), .force_drain(force_drain), .buf_addr(buf_addr), .buf_data(buf_data)
  );
  always_comb begin
    rd_pick = bus.rd_req & (full | !bus.host_req | rr_q == RR_RD);
    bus.rd_gnt = reset & !force_drain & rd_pick;
    bus.host_gnt = reset & !full & bus.host_req & !rd_pick;
    rd_ram = bus.rd_gnt & !hit;
    // only a missing pipeline read keeps a full buffer from draining
    drain = reset & full & (force_drain | !(bus.rd_req & !hit));
    load = reset & bus.wb_req & (!full | drain);
    bus.wb_ack = load;
    bus.busy = full;
    bus.mem_ce = drain | rd_ram | bus.host_gnt;
    bus.mem_we = drain | (bus.host_gnt & bus.host_we);
    bus.mem_a = !reset ? '0 : drain ? buf_addr : bus.host_gnt ? bus.host_addr : bus.rd_addr;
    bus.mem_d = !reset ? '0 : drain ? buf_data : bus.host_wdata;
    rr_d = bus.host_gnt ? RR_RD : bus.rd_gnt ? RR_HOST : rr_q;
    src_d = rd_ram ? SRC_RD : bus.rd_gnt ? SRC_FWD : (bus.host_gnt & !bus.host_we) ? SRC_HOST : SRC_NONE;
    bus.rd_valid = (src_q == SRC_RD) | (src_q == SRC_FWD);
    bus.rd_data = (src_q == SRC_RD) ? bus.mem_q : (src_q == SRC_FWD) ? fwd_q : rd_hold;
    bus.host_valid = src_q == SRC_HOST;
    bus.host_rdata = bus.host_valid ? bus.mem_q : host_hold;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= RR_RD;
      src_q <= SRC_NONE;
      rd_hold <= '0;
      host_hold <= '0;
    end else begin
      rr_q <= rr_d;
      src_q <= src_d;
      rd_hold <= bus.rd_data;
      host_hold <= bus.host_rdata;
    end
  end
  // the buffer may drain on the forwarding edge, so capture its data then
  always_ff @(posedge clk) fwd_q <= buf_data;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with hand-computed expectations against a behavioural RAM
module tb_dmem_arbiter;
  logic clk, reset;
  logic [7:0] ram [0:4095];
  logic [7:0] q;
  int n_chk = 0;
  int n_fail = 0;
  dmem_arbiter_if #(.A_WIDTH(12), .D_WIDTH(8)) bus ();
  dmem_arbiter #(.A_WIDTH(12), .D_WIDTH(8), .DEFER_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.mem_q = q;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
      else q <= ram[bus.mem_a];
    end
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wb_req = 0; bus.rd_req = 0; bus.host_req = 0; bus.host_we = 0;
  endtask
  task automatic settle();
    #2;
  endtask
  initial begin
    idle();
    bus.wb_addr = 0; bus.wb_data = 0; bus.rd_addr = 0; bus.host_addr = 0; bus.host_wdata = 0;
    // reset with every request raised
    reset = 0;
    bus.wb_req = 1; bus.rd_req = 1; bus.host_req = 1;
    tick();
    check("rst_rd_gnt", 16'(bus.rd_gnt), 16'd0);
    check("rst_host_gnt", 16'(bus.host_gnt), 16'd0);
    check("rst_wb_ack", 16'(bus.wb_ack), 16'd0);
    check("rst_mem_ce", 16'(bus.mem_ce), 16'd0);
    tick();
    check("rst_mem_we", 16'(bus.mem_we), 16'd0);
    idle();
    reset = 1;
    settle();
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_rd_valid", 16'(bus.rd_valid), 16'd0);
    check("rst_host_valid", 16'(bus.host_valid), 16'd0);
    check("rst_rd_data", 16'(bus.rd_data), 16'd0);
    tick();
    // host writes seed the RAM
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 12'h010; bus.host_wdata = 8'h5A;
    settle();
    check("hw_gnt", 16'(bus.host_gnt), 16'd1);
    check("hw_we", 16'(bus.mem_we), 16'd1);
    check("hw_a", 16'(bus.mem_a), 16'h010);
    check("hw_d", 16'(bus.mem_d), 16'h5A);
    tick();
    bus.host_addr = 12'h100; bus.host_wdata = 8'hC3;
    settle();
    check("hw_no_valid", 16'(bus.host_valid), 16'd0);
    check("hw2_gnt", 16'(bus.host_gnt), 16'd1);
    tick();
    idle();
    // lone pipeline read
    bus.rd_req = 1; bus.rd_addr = 12'h010;
    settle();
    check("rd_gnt", 16'(bus.rd_gnt), 16'd1);
    check("rd_ce", 16'(bus.mem_ce), 16'd1);
    check("rd_we", 16'(bus.mem_we), 16'd0);
    tick();
    idle();
    settle();
    check("rd_valid", 16'(bus.rd_valid), 16'd1);
    check("rd_data", 16'(bus.rd_data), 16'h5A);
    tick();
    settle();
    check("rd_valid_drop", 16'(bus.rd_valid), 16'd0);
    check("rd_data_hold", 16'(bus.rd_data), 16'h5A);
    tick();
    // posted write then forwarded read
    bus.wb_req = 1; bus.wb_addr = 12'h020; bus.wb_data = 8'h33;
    settle();
    check("fw_ack", 16'(bus.wb_ack), 16'd1);
    check("fw_ce0", 16'(bus.mem_ce), 16'd0);
    tick();
    idle();
    bus.rd_req = 1; bus.rd_addr = 12'h020;
    settle();
    check("fw_busy", 16'(bus.busy), 16'd1);
    check("fw_gnt", 16'(bus.rd_gnt), 16'd1);
    check("fw_we", 16'(bus.mem_we), 16'd1);
    check("fw_a", 16'(bus.mem_a), 16'h020);
    check("fw_d", 16'(bus.mem_d), 16'h33);
    tick();
    idle();
    settle();
    check("fw_valid", 16'(bus.rd_valid), 16'd1);
    check("fw_data", 16'(bus.rd_data), 16'h33);
    check("fw_busy_clr", 16'(bus.busy), 16'd0);
    tick();
    // back-to-back write-backs
    for (int i = 1; i <= 3; i++) begin
      bus.wb_req = 1; bus.wb_addr = 12'(i); bus.wb_data = 8'(i * 8'h11);
      settle();
      check($sformatf("b2b_ack%0d", i), 16'(bus.wb_ack), 16'd1);
      check($sformatf("b2b_we%0d", i), 16'(bus.mem_we), (i == 1) ? 16'd0 : 16'd1);
      if (i > 1) check($sformatf("b2b_a%0d", i), 16'(bus.mem_a), 16'(i - 1));
      tick();
    end
    idle();
    settle();
    check("b2b_last_we", 16'(bus.mem_we), 16'd1);
    check("b2b_last_a", 16'(bus.mem_a), 16'h003);
    check("b2b_last_d", 16'(bus.mem_d), 16'h33);
    check("b2b_busy", 16'(bus.busy), 16'd1);
    tick();
    settle();
    check("b2b_busy_clr", 16'(bus.busy), 16'd0);
    check("b2b_idle_ce", 16'(bus.mem_ce), 16'd0);
    // fresh pointer for the round-robin run
    reset = 0;
    tick();
    reset = 1;
    bus.rd_req = 1; bus.rd_addr = 12'h010;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 12'h100;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("rr_rd%0d", i), 16'(bus.rd_gnt), (i % 2 == 0) ? 16'd1 : 16'd0);
      check($sformatf("rr_host%0d", i), 16'(bus.host_gnt), (i % 2 == 0) ? 16'd0 : 16'd1);
      if (i == 1) check("rr_rd_data", 16'(bus.rd_data), 16'h5A);
      if (i == 2) check("rr_host_data", 16'(bus.host_rdata), 16'hC3);
      tick();
    end
    idle();
    settle();
    check("rr_host_valid", 16'(bus.host_valid), 16'd1);
    check("rr_host_rdata", 16'(bus.host_rdata), 16'hC3);
    tick();
    // defer limit: buffered write starved by read misses
    bus.wb_req = 1; bus.wb_addr = 12'h040; bus.wb_data = 8'h77;
    settle();
    check("df_ack", 16'(bus.wb_ack), 16'd1);
    tick();
    idle();
    bus.rd_req = 1; bus.rd_addr = 12'h010;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 12'h100;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("df_rd%0d", i), 16'(bus.rd_gnt), 16'd1);
      check($sformatf("df_host%0d", i), 16'(bus.host_gnt), 16'd0);
      check($sformatf("df_we%0d", i), 16'(bus.mem_we), 16'd0);
      tick();
    end
    settle();
    check("df_force_rd", 16'(bus.rd_gnt), 16'd0);
    check("df_force_host", 16'(bus.host_gnt), 16'd0);
    check("df_force_we", 16'(bus.mem_we), 16'd1);
    check("df_force_a", 16'(bus.mem_a), 16'h040);
    check("df_rd_data", 16'(bus.rd_data), 16'h5A);
    tick();
    settle();
    check("df_busy_clr", 16'(bus.busy), 16'd0);
    check("df_host_after", 16'(bus.host_gnt), 16'd1);
    check("df_rd_after", 16'(bus.rd_gnt), 16'd0);
    tick();
    idle();
    bus.rd_req = 1; bus.rd_addr = 12'h040;
    settle();
    check("df_ram_rd_gnt", 16'(bus.rd_gnt), 16'd1);
    tick();
    idle();
    settle();
    check("df_ram_data", 16'(bus.rd_data), 16'h77);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
